// File: rtl/elevator_request_scheduler_if.sv
// Car-controller bundle between the request scheduler and its environment:
// call buttons and car feedback in, dispatch command and status out.
interface elevator_request_scheduler_if #(
    parameter int NUM_FLOORS = 10
);
    logic [NUM_FLOORS-1:0] call_req;
    logic [3:0]            current_floor;
    logic                  car_idle;
    logic [3:0]            target_floor;
    logic                  target_valid;
    logic                  dir_up;
    logic                  door_open;
    logic                  served;
    logic [NUM_FLOORS-1:0] pending;

    modport master (
        output call_req, current_floor, car_idle,
        input  target_floor, target_valid, dir_up, door_open, served, pending
    );

    modport slave (
        input  call_req, current_floor, car_idle,
        output target_floor, target_valid, dir_up, door_open, served, pending
    );
endinterface

// File: rtl/elevator_request_scheduler.sv
// SCAN-style elevator request scheduler: latches floor calls, dispatches the
// car to the nearest pending floor in the sweep direction and times door dwell.
module elevator_request_scheduler #(
    parameter int          NUM_FLOORS   = 10,
    parameter logic [15:0] DWELL_CYCLES = 16'd1000
) (
    input logic                         clk,
    input logic                         rst_n,
    elevator_request_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DOOR     = 2'd2
    } state_t;

    localparam logic [15:0] DWELL_LAST  = DWELL_CYCLES - 16'd1;
    localparam logic [4:0]  FLOOR_LIMIT = 5'(NUM_FLOORS);

    state_t                state_r;
    state_t                state_s;
    logic [NUM_FLOORS-1:0] pending_r;
    logic [NUM_FLOORS-1:0] pending_s;
    logic [NUM_FLOORS-1:0] clear_s;
    logic [3:0]            target_r;
    logic [3:0]            target_s;
    logic                  target_valid_r;
    logic                  target_valid_s;
    logic                  dir_up_r;
    logic                  dir_up_s;
    logic                  door_open_r;
    logic                  door_open_s;
    logic                  served_r;
    logic                  served_s;
    logic [15:0]           dwell_r;
    logic [15:0]           dwell_s;

    logic                  cur_valid_s;
    logic [NUM_FLOORS-1:0] cur_mask_s;
    logic [NUM_FLOORS-1:0] search_s;
    logic                  up_found_s;
    logic [3:0]            up_idx_s;
    logic                  dn_found_s;
    logic [3:0]            dn_idx_s;

    // Nearest pending floor above and below the car; an out-of-range floor matches nothing.
    always_comb begin
        cur_valid_s = ({1'b0, bus.current_floor} < FLOOR_LIMIT);
        // While dispatching, this cycle's calls are visible so an intermediate stop retargets on the next edge.
        search_s    = (state_r == DISPATCH) ? (pending_r | bus.call_req) : pending_r;
        cur_mask_s  = '0;
        up_found_s  = 1'b0;
        up_idx_s    = 4'd0;
        dn_found_s  = 1'b0;
        dn_idx_s    = 4'd0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            cur_mask_s[i] = cur_valid_s && (bus.current_floor == i[3:0]);
            dn_found_s    = dn_found_s | (cur_valid_s && search_s[i] && (i[3:0] < bus.current_floor));
            dn_idx_s      = (cur_valid_s && search_s[i] && (i[3:0] < bus.current_floor)) ? i[3:0] : dn_idx_s;
        end
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            up_found_s = up_found_s | (cur_valid_s && search_s[i] && (i[3:0] > bus.current_floor));
            up_idx_s   = (cur_valid_s && search_s[i] && (i[3:0] > bus.current_floor)) ? i[3:0] : up_idx_s;
        end
    end

    // Next-state, target selection, request clearing and dwell timing.
    always_comb begin
        state_s        = state_r;
        target_s       = target_r;
        target_valid_s = 1'b0;
        dir_up_s       = dir_up_r;
        served_s       = 1'b0;
        dwell_s        = dwell_r;
        clear_s        = '0;
        case (state_r)
            IDLE: begin
                if (!cur_valid_s) begin
                    state_s = IDLE;
                end else if (|(pending_r & cur_mask_s)) begin
                    state_s  = DOOR;
                    clear_s  = cur_mask_s;
                    served_s = 1'b1;
                    dwell_s  = 16'd0;
                end else if (|pending_r) begin
                    state_s        = DISPATCH;
                    target_valid_s = 1'b1;
                    if (dir_up_r) begin
                        if (up_found_s) begin
                            target_s = up_idx_s;
                        end else begin
                            target_s = dn_idx_s;
                            dir_up_s = 1'b0;
                        end
                    end else begin
                        if (dn_found_s) begin
                            target_s = dn_idx_s;
                        end else begin
                            target_s = up_idx_s;
                            dir_up_s = 1'b1;
                        end
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            DISPATCH: begin
                target_valid_s = 1'b1;
                if (!cur_valid_s) begin
                    state_s = DISPATCH;
                end else if (bus.car_idle && (bus.current_floor == target_r)) begin
                    state_s        = DOOR;
                    clear_s        = cur_mask_s;
                    served_s       = 1'b1;
                    dwell_s        = 16'd0;
                    target_valid_s = 1'b0;
                end else if (dir_up_r && up_found_s && (up_idx_s < target_r)) begin
                    target_s = up_idx_s;
                end else if (!dir_up_r && dn_found_s && (dn_idx_s > target_r)) begin
                    target_s = dn_idx_s;
                end else begin
                    target_s = target_r;
                end
            end
            DOOR: begin
                if (!cur_valid_s) begin
                    state_s = DOOR;
                end else if (|(bus.call_req & cur_mask_s)) begin
                    clear_s  = cur_mask_s;
                    served_s = 1'b1;
                    dwell_s  = 16'd0;
                end else if (dwell_r == DWELL_LAST) begin
                    state_s = IDLE;
                    dwell_s = 16'd0;
                end else begin
                    dwell_s = dwell_r + 16'd1;
                end
            end
            default: begin
                state_s = IDLE;
                dwell_s = 16'd0;
            end
        endcase
        // A stop at a floor absorbs a call for that floor raised in the same cycle.
        pending_s   = (pending_r | bus.call_req) & ~clear_s;
        door_open_s = (state_s == DOOR);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            pending_r      <= '0;
            target_r       <= 4'd0;
            target_valid_r <= 1'b0;
            dir_up_r       <= 1'b1;
            door_open_r    <= 1'b0;
            served_r       <= 1'b0;
            dwell_r        <= 16'd0;
        end else begin
            state_r        <= state_s;
            pending_r      <= pending_s;
            target_r       <= target_s;
            target_valid_r <= target_valid_s;
            dir_up_r       <= dir_up_s;
            door_open_r    <= door_open_s;
            served_r       <= served_s;
            dwell_r        <= dwell_s;
        end
    end

    assign bus.target_floor = target_r;
    assign bus.target_valid = target_valid_r;
    assign bus.dir_up       = dir_up_r;
    assign bus.door_open    = door_open_r;
    assign bus.served       = served_r;
    assign bus.pending      = pending_r;

endmodule
